gpioemu_host: RTL and testbench
===============================

Name: gpioemu_host

Overview:
Bus initiator for the gpioemu multiply/popcount peripheral, driving the other end of its saddress/srd/swr/sdata register bus. It accepts one (A1, A2) command at a time and writes both operands and the control/start register. It then polls the status register, reads back W (low 32 bits of the product) and L (ones count), and returns them on a response interface. It sits between the test/firmware side and the emulated peripheral, replacing hand-driven register sequences.

Parameters:
STROBE_CYCLES, 2, cycles srd/swr held high per transaction (>=1)
START_WAIT, 4, idle cycles after start write before first status poll
POLL_GAP, 2, idle cycles between consecutive status polls
MAX_POLLS, 16, status reads allowed before timeout (>=1)
ADDR_A1, 16'h037F, operand A1 register
ADDR_A2, 16'h0388, operand A2 register
ADDR_CTRL, 16'h03A0, control (write = start) / status B (read)
ADDR_W, 16'h0390, result W register
ADDR_L, 16'h0398, ones count L register

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only; transfer when cmd_valid & cmd_ready
cmd_a1  in  24  operand A1
cmd_a2  in  24  operand A2
rsp_valid  out  1  one-cycle pulse, response fields valid
rsp_w  out  32  W read back
rsp_ones  out  24  L read back (sdata bits [23:0])
rsp_ovf  out  1  product exceeded 32 bits (final status bit0 == 0)
rsp_timeout  out  1  MAX_POLLS exhausted without completion
busy  out  1  high from command accept until rsp_valid cycle inclusive
saddress  out  16  bus address
srd  out  1  read strobe
swr  out  1  write strobe
sdata_out  out  32  write data to peripheral sdata_in
sdata_in  in  32  read data from peripheral sdata_out

Behaviour:
- Reset (sync, high): state IDLE, all outputs 0 except cmd_ready=1; captured operands, poll counter, wait counter cleared. Reset mid-transaction drops srd/swr at that edge, no completion of sequence, no rsp_valid.
- Bus transaction = SETUP (1 cycle: saddress/sdata_out driven, strobes low) -> STROBE (STROBE_CYCLES cycles, exactly one strobe high, address/data stable) -> HOLD (1 cycle, strobes low, address/data still stable). Length 2+STROBE_CYCLES. srd and swr never high together. Read data captured from sdata_in on the edge entering HOLD.
- Outside transactions saddress=0, sdata_out=0, strobes low.
- States: IDLE -> WR_A1 (ADDR_A1, {8'h0,a1}) -> WR_A2 (ADDR_A2, {8'h0,a2}) -> WR_START (ADDR_CTRL, data 0) -> WAIT (START_WAIT cycles) -> RD_STAT (ADDR_CTRL) -> [status[1]==1: RD_W; else if polls==MAX_POLLS: RESP with timeout; else WAIT POLL_GAP cycles -> RD_STAT] -> RD_W (ADDR_W) -> RD_L (ADDR_L) -> RESP (1 cycle) -> IDLE.
- Operands captured at command accept; cmd_a1/cmd_a2 changes afterwards ignored.
- Poll counter counts issued status reads; increments at each RD_STAT HOLD.
- RESP: rsp_valid=1 one cycle; rsp_w, rsp_ones, rsp_ovf, rsp_timeout held stable until next RESP. On timeout: rsp_w=0, rsp_ones=0, rsp_ovf=0, rsp_timeout=1, no W/L reads issued.
- rsp_ovf = ~status[0] from final successful poll.
- cmd_valid while busy: ignored (cmd_ready=0); no queueing. Earliest next accept: cycle after RESP.
- No wrap concerns: poll counter width ceil(log2(MAX_POLLS+1)).

Test Plan:
- a1=3, a2=5, responder model sets status=2'b11 at 3rd poll -> bus trace WR 037F=3, WR 0388=5, WR 03A0=0, 3x RD 03A0, RD 0390, RD 0398; rsp_w=15, rsp_ones=4, rsp_ovf=0, rsp_timeout=0, single rsp_valid pulse.
- a1=a2=24'hFFFFFF, status=2'b10 on completion -> rsp_w=32'hFE000001, rsp_ones=8, rsp_ovf=1.
- Timing with STROBE_CYCLES=2: each transaction exactly 4 cycles; swr high cycles 2-3 of WR_A1 relative to accept+1; saddress stable SETUP through HOLD; srd/swr never overlap (assertion).
- Responder never sets status[1] -> exactly 16 status reads, rsp_timeout=1, rsp_w=0, no reads of 0390/0398.
- cmd_valid held high with two different operand pairs -> second accepted only in cycle after first rsp_valid; busy low exactly one cycle (IDLE) between.
- Assert reset during STROBE of WR_A2 -> srd/swr/saddress 0 next cycle, cmd_ready=1, no rsp_valid; fresh command then completes normally.

Source files
------------

// File: rtl/gpioemu_host.sv
// Register-bus initiator for the gpioemu multiply/popcount peripheral.
// It takes one (A1, A2) command, runs the write/poll/read sequence on the bus and returns W, L and the flags.
module gpioemu_host #(
    parameter int          STROBE_CYCLES = 2,
    parameter int          START_WAIT    = 4,
    parameter int          POLL_GAP      = 2,
    parameter int          MAX_POLLS     = 16,
    parameter logic [15:0] ADDR_A1       = 16'h037F,
    parameter logic [15:0] ADDR_A2       = 16'h0388,
    parameter logic [15:0] ADDR_CTRL     = 16'h03A0,
    parameter logic [15:0] ADDR_W        = 16'h0390,
    parameter logic [15:0] ADDR_L        = 16'h0398
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_ones,
    output logic        rsp_ovf,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam int SCW  = $clog2(STROBE_CYCLES + 1);
    localparam int PCW  = $clog2(MAX_POLLS + 1);
    localparam int WMAX = (START_WAIT > POLL_GAP) ? START_WAIT : POLL_GAP;
    localparam int WCW  = (WMAX < 2) ? 1 : $clog2(WMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A1,
        S_WR_A2,
        S_WR_START,
        S_WAIT,
        S_RD_STAT,
        S_RD_W,
        S_RD_L,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    state_t      state;
    phase_t      phase;
    logic [SCW-1:0] scnt;
    logic [WCW-1:0] wcnt;
    logic [PCW-1:0] poll_cnt;
    logic [23:0] a1_q;
    logic [23:0] a2_q;
    logic [31:0] rd_data;
    logic [31:0] w_q;
    logic        ovf_q;
    logic        rd_xfer;

    assign rd_xfer = (state == S_RD_STAT) || (state == S_RD_W) || (state == S_RD_L);

    // Address/data are loaded on the edge entering SETUP and only change on the edge leaving HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            phase       <= PH_SETUP;
            scnt        <= '0;
            wcnt        <= '0;
            poll_cnt    <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            rd_data     <= '0;
            w_q         <= '0;
            ovf_q       <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_w       <= '0;
            rsp_ones    <= '0;
            rsp_ovf     <= 1'b0;
            rsp_timeout <= 1'b0;
            saddress    <= '0;
            sdata_out   <= '0;
            srd         <= 1'b0;
            swr         <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        a1_q      <= cmd_a1;
                        a2_q      <= cmd_a2;
                        poll_cnt  <= '0;
                        ovf_q     <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_WR_A1;
                        phase     <= PH_SETUP;
                        saddress  <= ADDR_A1;
                        sdata_out <= {8'h00, cmd_a1};
                    end
                end

                S_WAIT: begin
                    if (wcnt <= WCW'(1)) begin
                        state    <= S_RD_STAT;
                        phase    <= PH_SETUP;
                        saddress <= ADDR_CTRL;
                    end else begin
                        wcnt <= wcnt - WCW'(1);
                    end
                end

                S_RESP: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                S_WR_A1, S_WR_A2, S_WR_START, S_RD_STAT, S_RD_W, S_RD_L: begin
                    case (phase)
                        PH_SETUP: begin
                            phase <= PH_STROBE;
                            scnt  <= SCW'(1);
                            if (rd_xfer) srd <= 1'b1;
                            else         swr <= 1'b1;
                        end

                        PH_STROBE: begin
                            if (scnt == SCW'(STROBE_CYCLES)) begin
                                phase   <= PH_HOLD;
                                srd     <= 1'b0;
                                swr     <= 1'b0;
                                rd_data <= sdata_in;
                            end else begin
                                scnt <= scnt + SCW'(1);
                            end
                        end

                        PH_HOLD: begin
                            phase <= PH_SETUP;
                            case (state)
                                S_WR_A1: begin
                                    state     <= S_WR_A2;
                                    saddress  <= ADDR_A2;
                                    sdata_out <= {8'h00, a2_q};
                                end
                                S_WR_A2: begin
                                    state     <= S_WR_START;
                                    saddress  <= ADDR_CTRL;
                                    sdata_out <= '0;
                                end
                                S_WR_START: begin
                                    sdata_out <= '0;
                                    if (START_WAIT == 0) begin
                                        state    <= S_RD_STAT;
                                        saddress <= ADDR_CTRL;
                                    end else begin
                                        state    <= S_WAIT;
                                        wcnt     <= WCW'(START_WAIT);
                                        saddress <= '0;
                                    end
                                end
                                S_RD_STAT: begin
                                    poll_cnt  <= poll_cnt + PCW'(1);
                                    sdata_out <= '0;
                                    if (rd_data[1]) begin
                                        // bit0 set means the product fit in 32 bits
                                        ovf_q    <= ~rd_data[0];
                                        state    <= S_RD_W;
                                        saddress <= ADDR_W;
                                    end else if (poll_cnt == PCW'(MAX_POLLS - 1)) begin
                                        state       <= S_RESP;
                                        saddress    <= '0;
                                        rsp_valid   <= 1'b1;
                                        rsp_w       <= '0;
                                        rsp_ones    <= '0;
                                        rsp_ovf     <= 1'b0;
                                        rsp_timeout <= 1'b1;
                                    end else if (POLL_GAP == 0) begin
                                        state    <= S_RD_STAT;
                                        saddress <= ADDR_CTRL;
                                    end else begin
                                        state    <= S_WAIT;
                                        wcnt     <= WCW'(POLL_GAP);
                                        saddress <= '0;
                                    end
                                end
                                S_RD_W: begin
                                    w_q      <= rd_data;
                                    state    <= S_RD_L;
                                    saddress <= ADDR_L;
                                end
                                S_RD_L: begin
                                    state       <= S_RESP;
                                    saddress    <= '0;
                                    sdata_out   <= '0;
                                    rsp_valid   <= 1'b1;
                                    rsp_w       <= w_q;
                                    rsp_ones    <= rd_data[23:0];
                                    rsp_ovf     <= ovf_q;
                                    rsp_timeout <= 1'b0;
                                end
                                default: begin
                                    state    <= S_IDLE;
                                    saddress <= '0;
                                end
                            endcase
                        end

                        default: phase <= PH_SETUP;
                    endcase
                end

                default: begin
                    state     <= S_IDLE;
                    phase     <= PH_SETUP;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    saddress  <= '0;
                    sdata_out <= '0;
                    srd       <= 1'b0;
                    swr       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpioemu_host.sv
// Directed bench for gpioemu_host: a behavioural peripheral answers the bus, a monitor logs transactions,
// and hand-computed results are compared through one check task.
module tb_gpioemu_host;

    localparam logic [15:0] A_A1   = 16'h037F;
    localparam logic [15:0] A_A2   = 16'h0388;
    localparam logic [15:0] A_CTRL = 16'h03A0;
    localparam logic [15:0] A_W    = 16'h0390;
    localparam logic [15:0] A_L    = 16'h0398;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_a1 = '0;
    logic [23:0] cmd_a2 = '0;
    logic        rsp_valid;
    logic [31:0] rsp_w;
    logic [23:0] rsp_ones;
    logic        rsp_ovf;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    always #5 clk = ~clk;

    gpioemu_host dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a1      (cmd_a1),
        .cmd_a2      (cmd_a2),
        .rsp_valid   (rsp_valid),
        .rsp_w       (rsp_w),
        .rsp_ones    (rsp_ones),
        .rsp_ovf     (rsp_ovf),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .saddress    (saddress),
        .srd         (srd),
        .swr         (swr),
        .sdata_out   (sdata_out),
        .sdata_in    (sdata_in)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Peripheral model: status reports done once done_at status reads have happened since the start write.
    logic [23:0] reg_a1 = '0;
    logic [23:0] reg_a2 = '0;
    logic [1:0]  done_status = 2'b11;
    int          done_at = 1;
    int          stat_reads = 0;
    int          w_reads = 0;
    int          l_reads = 0;
    logic [31:0] prod;

    assign prod = {8'h00, reg_a1} * {8'h00, reg_a2};

    always @* begin
        sdata_in = 32'h0;
        case (saddress)
            A_CTRL:  sdata_in = (stat_reads >= done_at) ? {30'h0, done_status} : 32'h0;
            A_W:     sdata_in = prod;
            A_L:     sdata_in = 32'($countones(prod));
            default: sdata_in = 32'h0;
        endcase
    end

    // Bus monitor: logs every transaction and counts protocol violations.
    logic [48:0] act_q[$];
    logic [48:0] exp_q[$];
    logic        p_srd = 1'b0;
    logic        p_swr = 1'b0;
    logic [15:0] p_addr = '0;
    logic [31:0] p_data = '0;
    logic [15:0] t_addr = '0;
    logic [31:0] t_data = '0;
    int          run = 0;
    int          bus_err = 0;
    int          overlap_cnt = 0;
    int          rsp_pulses = 0;
    bit          mon_en = 1'b1;

    always @(negedge clk) begin
        if (srd && swr) overlap_cnt++;
        if (rsp_valid) rsp_pulses++;
        if ((srd || swr) && !(p_srd || p_swr)) begin
            if (mon_en && (saddress != p_addr || sdata_out != p_data)) bus_err++;
            t_addr = saddress;
            t_data = sdata_out;
            run = 1;
            act_q.push_back({swr, saddress, swr ? sdata_out : 32'h0});
            if (swr) begin
                if (saddress == A_A1) reg_a1 = sdata_out[23:0];
                if (saddress == A_A2) reg_a2 = sdata_out[23:0];
                if (saddress == A_CTRL) stat_reads = 0;
            end else begin
                if (saddress == A_CTRL) stat_reads++;
                if (saddress == A_W) w_reads++;
                if (saddress == A_L) l_reads++;
            end
        end else if (srd || swr) begin
            run++;
            if (mon_en && (saddress != t_addr || sdata_out != t_data)) bus_err++;
        end else if (p_srd || p_swr) begin
            if (mon_en && (run != 2 || saddress != t_addr || sdata_out != t_data)) bus_err++;
        end
        p_srd  = srd;
        p_swr  = swr;
        p_addr = saddress;
        p_data = sdata_out;
    end

    // Driver tasks
    task automatic issue(input logic [23:0] a1, input logic [23:0] a2);
        int i;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a1 = a1;
        cmd_a2 = a2;
        for (i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) check("accept_wait", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a1 = 24'hABCDEF;
        cmd_a2 = 24'h123456;
    endtask

    logic [31:0] r_w;
    logic [23:0] r_ones;
    logic        r_ovf;
    logic        r_to;
    logic        r_busy;

    task automatic wait_rsp(input int max_cycles);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got    = 1'b1;
                r_w    = rsp_w;
                r_ones = rsp_ones;
                r_ovf  = rsp_ovf;
                r_to   = rsp_timeout;
                r_busy = busy;
            end
        end
        if (!got) check("rsp_wait", 32'(got), 32'h1);
        else begin
            @(negedge clk);
            check("rsp_pulse_width", 32'(rsp_valid), 32'h0);
        end
    endtask

    int snap;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_saddress", 32'(saddress), 32'h0);
        check("rst_strobes", 32'({srd, swr}), 32'h0);
        check("rst_rsp", 32'({rsp_valid, rsp_ovf, rsp_timeout}), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 3 * 5, done on the third poll; bus timing checked cycle by cycle after accept
        done_at = 3;
        done_status = 2'b11;
        act_q.delete();
        snap = rsp_pulses;
        issue(24'd3, 24'd5);
        @(negedge clk);
        check("c1_setup_addr", 32'(saddress), 32'(A_A1));
        check("c1_setup_data", sdata_out, 32'd3);
        check("c1_setup_swr", 32'({srd, swr}), 32'h0);
        check("c1_busy", 32'({busy, cmd_ready}), 32'h2);
        @(negedge clk);
        check("c2_swr", 32'({srd, swr}), 32'h1);
        @(negedge clk);
        check("c3_swr", 32'({srd, swr}), 32'h1);
        @(negedge clk);
        check("c4_hold_swr", 32'({srd, swr}), 32'h0);
        check("c4_hold_addr", 32'(saddress), 32'(A_A1));
        @(negedge clk);
        check("c5_a2_addr", 32'(saddress), 32'(A_A2));
        check("c5_a2_data", sdata_out, 32'd5);
        wait_rsp(500);
        check("t1_w", r_w, 32'd15);
        check("t1_ones", 32'(r_ones), 32'd4);
        check("t1_ovf", 32'(r_ovf), 32'h0);
        check("t1_timeout", 32'(r_to), 32'h0);
        check("t1_busy_at_rsp", 32'(r_busy), 32'h1);
        repeat (3) @(negedge clk);
        check("t1_one_pulse", 32'(rsp_pulses - snap), 32'd1);
        check("t1_stat_reads", 32'(stat_reads), 32'd3);
        exp_q.delete();
        exp_q.push_back({1'b1, A_A1, 32'd3});
        exp_q.push_back({1'b1, A_A2, 32'd5});
        exp_q.push_back({1'b1, A_CTRL, 32'd0});
        exp_q.push_back({1'b0, A_CTRL, 32'd0});
        exp_q.push_back({1'b0, A_CTRL, 32'd0});
        exp_q.push_back({1'b0, A_CTRL, 32'd0});
        exp_q.push_back({1'b0, A_W, 32'd0});
        exp_q.push_back({1'b0, A_L, 32'd0});
        check("t1_trace_len", 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) begin
                check("t1_trace_hdr", 32'(act_q[i][48:32]), 32'(exp_q[i][48:32]));
                check("t1_trace_data", act_q[i][31:0], exp_q[i][31:0]);
            end
        end

        // overflow case: 0xFFFFFF squared
        done_at = 1;
        done_status = 2'b10;
        issue(24'hFFFFFF, 24'hFFFFFF);
        wait_rsp(500);
        check("t2_w", r_w, 32'hFE000001);
        check("t2_ones", 32'(r_ones), 32'd8);
        check("t2_ovf", 32'(r_ovf), 32'h1);
        check("t2_timeout", 32'(r_to), 32'h0);

        // peripheral never completes
        done_at = 1000;
        snap = w_reads + l_reads;
        issue(24'd7, 24'd7);
        wait_rsp(1000);
        check("t4_timeout", 32'(r_to), 32'h1);
        check("t4_w", r_w, 32'h0);
        check("t4_ones", 32'(r_ones), 32'h0);
        check("t4_ovf", 32'(r_ovf), 32'h0);
        check("t4_stat_reads", 32'(stat_reads), 32'd16);
        check("t4_no_wl_reads", 32'(w_reads + l_reads - snap), 32'd0);

        // cmd_valid held across two commands
        done_at = 1;
        done_status = 2'b11;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a1 = 24'd2;
        cmd_a2 = 24'd7;
        @(posedge clk);
        #1;
        cmd_a1 = 24'd6;
        cmd_a2 = 24'd9;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 500 && !got; i++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    got = 1'b1;
                    check("t5_first_w", rsp_w, 32'd14);
                    check("t5_first_ones", 32'(rsp_ones), 32'd3);
                    check("t5_ready_at_rsp", 32'(cmd_ready), 32'h0);
                end
            end
            if (!got) check("t5_first_wait", 32'(got), 32'h1);
        end
        @(negedge clk);
        check("t5_idle_gap", 32'({busy, cmd_ready}), 32'h1);
        @(negedge clk);
        check("t5_second_accept", 32'({busy, cmd_ready}), 32'h2);
        cmd_valid = 1'b0;
        wait_rsp(500);
        check("t5_second_w", r_w, 32'd54);
        check("t5_second_ones", 32'(r_ones), 32'd4);

        // reset during the write strobe of A2
        issue(24'd1, 24'd1);
        repeat (6) @(negedge clk);
        check("t6_pre_strobe", 32'({swr, saddress}), 32'({1'b1, A_A2}));
        mon_en = 1'b0;
        reset = 1'b1;
        snap = rsp_pulses;
        @(negedge clk);
        check("t6_strobes", 32'({srd, swr}), 32'h0);
        check("t6_saddress", 32'(saddress), 32'h0);
        check("t6_ready", 32'({busy, cmd_ready}), 32'h1);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_rsp", 32'(rsp_pulses - snap), 32'd0);
        mon_en = 1'b1;
        issue(24'd4, 24'd5);
        wait_rsp(500);
        check("t6_w", r_w, 32'd20);
        check("t6_ones", 32'(r_ones), 32'd2);
        check("t6_timeout", 32'(r_to), 32'h0);

        repeat (2) @(negedge clk);
        check("bus_timing", 32'(bus_err), 32'd0);
        check("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
